// File: rtl/bootrom_pkg.sv
// bootrom_pkg: shared constants and FSM encoding for the BootROM arbiter.
//   ROM_ADDR_W / ROM_DATA_W : geometry of the 2048 x 32 BootROM macro
//   state_t                 : arbiter FSM encoding
package bootrom_pkg;

    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    in  NUM_REQ   request vector
//   ptr    in  IDX_W     highest-priority index this cycle
//   enable in  1         when low, no grant is produced
//   grant  out NUM_REQ   one-hot grant (or zero)
//   idx    out IDX_W     index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   pos;

    // Scan NUM_REQ positions starting at ptr, wrapping; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (enable && !found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares the single-port BootROM among NUM_REQ requesters.
// One transaction in flight; round-robin grant; valid/ready on both sides.
//   clock, reset          clock / asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or 0)
//   req_addr              packed byte addresses, requester i at [i*ADDR_W +: ADDR_W]
//   resp_valid/resp_ready response handshake
//   resp_data/id/err      response payload (data 0 on misaligned error)
//   rom_me/rom_oe         ROM memory/output enables
//   rom_address, rom_q    ROM word address and read data
module bootrom_arbiter
    import bootrom_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 13,
    parameter int ROM_ADDR_W = bootrom_pkg::ROM_ADDR_W,
    parameter int DATA_W     = bootrom_pkg::ROM_DATA_W,
    parameter int ID_W       = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err,
    output logic                      rom_me,
    output logic                      rom_oe,
    output logic [ROM_ADDR_W-1:0]     rom_address,
    input  logic [DATA_W-1:0]         rom_q
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (ROM_ADDR_W != ADDR_W - 2) begin : g_chk_aw
        $error("bootrom_arbiter: ROM_ADDR_W must equal ADDR_W-2");
    end
    if (NUM_REQ > 2**ID_W || ID_W < IDX_W) begin : g_chk_id
        $error("bootrom_arbiter: ID_W too narrow for NUM_REQ");
    end

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, id_q, gidx;
    logic [ROM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  err_q;
    logic [NUM_REQ-1:0]    grant;
    logic                  take;
    logic                  misal;
    logic [ADDR_W-1:0]     gaddr;
    logic [ADDR_W-1:0]     addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end

    // Reset gates the arbiter so req_ready is 0 while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (state_q == IDLE && !reset),
        .grant  (grant),
        .idx    (gidx)
    );

    assign take  = |grant;
    assign gaddr = addr_arr[gidx];
    assign misal = |gaddr[1:0];

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_id     = '0;
        resp_err    = 1'b0;
        rom_me      = 1'b0;
        rom_oe      = 1'b0;
        rom_address = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (take) state_d = misal ? RESP : READ;
            end
            READ: begin
                rom_me      = 1'b1;
                rom_address = addr_q;
                state_d     = CAPT;
            end
            CAPT: begin
                rom_oe      = 1'b1;
                rom_address = addr_q;
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = data_q;
                resp_id    = ID_W'(id_q);
                resp_err   = err_q;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && take) begin
                id_q   <= gidx;
                addr_q <= gaddr[ADDR_W-1:2];
                ptr_q  <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
                err_q  <= misal;
                // Cleared here so a misaligned response carries zero data.
                data_q <= '0;
            end
            if (state_q == CAPT) data_q <= rom_q;
        end
    end

endmodule

// File: tb/tb_bootrom_arbiter.sv
module tb_bootrom_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [25:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [2:0]  resp_id;
    logic        resp_err;
    logic        rom_me, rom_oe;
    logic [10:0] rom_address;
    logic [31:0] rom_q;

    bootrom_arbiter #(.NUM_REQ(2), .ADDR_W(13), .ROM_ADDR_W(11), .DATA_W(32), .ID_W(3)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
        .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q)
    );

    always #5 clock = ~clock;

    // ROM model: 1-cycle sync read, data visible while oe is high.
    logic [31:0] mem [2048];
    logic [31:0] rom_lat = '0;
    always @(posedge clock) if (rom_me) rom_lat <= mem[rom_address];
    assign rom_q = rom_oe ? rom_lat : 32'h0;

    typedef struct { logic [31:0] data; logic [2:0] id; logic err; } exp_t;
    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] id, input logic err);
        exp_t e;
        e.data = d; e.id = id; e.err = err;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a grant; gap = negedges waited including the grant cycle.
    task automatic wait_grant(output int g, output int gap);
        g = -1; gap = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (|req_ready) begin
                gap = k;
                g = req_ready[1] ? 1 : 0;
                break;
            end
        end
        if (g < 0) begin
            n_chk++; n_fail++;
            $display("FAIL grant_timeout: got none expected a grant within 50 cycles");
        end
    endtask

    // Monitor: compare every accepted response against the scoreboard.
    always @(negedge clock) begin
        if (!reset && resp_valid === 1'b1 && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got id %0d data %h expected none", resp_id, resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    function automatic logic [31:0] outs_or();
        return 32'(|{req_ready, resp_valid, resp_data, resp_id, resp_err, rom_me, rom_oe, rom_address});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g, gap;
        for (int i = 0; i < 2048; i++) mem[i] = {16'h5A5A, 16'(i)};
        mem[2]    = 32'hDEADBEEF;
        mem[2047] = 32'hCAFE07FF;

        // Reset state
        req_valid = 2'b11;
        @(negedge clock);
        chk("reset_outs", outs_or(), 0);
        req_valid = 2'b00;
        @(posedge clock); #1 reset = 1'b0;

        // 1: single aligned read, cycle-exact timing
        @(posedge clock); #1 req_valid = 2'b01; req_addr[12:0] = 13'h008;
        wait_grant(g, gap);
        chk("t1_grant", 32'(req_ready), 32'b01);
        push(32'hDEADBEEF, 3'd0, 1'b0);
        @(posedge clock); #1 req_valid = 2'b00;
        @(negedge clock);
        chk("t1_me", 32'({rom_me, rom_oe}), 32'b10);
        chk("t1_addr", 32'(rom_address), 32'd2);
        @(negedge clock);
        chk("t1_oe", 32'({rom_me, rom_oe}), 32'b01);
        @(negedge clock);
        chk("t1_valid_t3", 32'(resp_valid), 1);
        @(negedge clock);
        chk("t1_done", 32'(resp_valid), 0);

        // 3: misaligned from requester 1 (pointer now 1)
        @(posedge clock); #1 req_valid = 2'b10; req_addr[25:13] = 13'h006;
        wait_grant(g, gap);
        chk("t3_grant", 32'(req_ready), 32'b10);
        chk("t3_me_t0", 32'(rom_me), 0);
        push(32'h0, 3'd1, 1'b1);
        @(posedge clock); #1 req_valid = 2'b00;
        @(negedge clock);
        chk("t3_valid_t1", 32'(resp_valid), 1);
        chk("t3_me_t1", 32'(rom_me), 0);
        @(negedge clock);
        chk("t3_done", 32'(resp_valid), 0);

        // 2: contention, grants alternate 0,1,0,1 every 4 cycles
        @(posedge clock); #1 req_valid = 2'b11; req_addr = {13'h004, 13'h000};
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, gap);
            chk("t2_grant", 32'(g), 32'(k % 2));
            if (k > 0) chk("t2_gap", 32'(gap), 4);
            push((k % 2) ? 32'h5A5A0001 : 32'h5A5A0000, 3'(k % 2), 1'b0);
        end
        @(posedge clock); #1 req_valid = 2'b00;
        repeat (4) @(negedge clock);

        // 4: backpressure for 10 cycles, next grant right after handshake
        @(posedge clock); #1 resp_ready = 1'b0; req_valid = 2'b01; req_addr[12:0] = 13'h010;
        wait_grant(g, gap);
        chk("t4_grant", 32'(req_ready), 32'b01);
        push(32'h5A5A0004, 3'd0, 1'b0);
        @(posedge clock); #1 req_valid = 2'b10; req_addr[25:13] = 13'h014;
        repeat (3) @(negedge clock);
        chk("t4_valid", 32'(resp_valid), 1);
        repeat (10) begin
            @(negedge clock);
            chk("t4_hold_valid", 32'(resp_valid), 1);
            chk("t4_hold_data", resp_data, 32'h5A5A0004);
            chk("t4_hold_rdy", 32'({resp_id, req_ready}), 0);
        end
        @(posedge clock); #1 resp_ready = 1'b1;
        @(negedge clock);
        chk("t4_no_same_cycle", 32'(req_ready), 0);
        @(negedge clock);
        chk("t4_next_grant", 32'(req_ready), 32'b10);
        push(32'h5A5A0005, 3'd1, 1'b0);
        @(posedge clock); #1 req_valid = 2'b00;
        repeat (4) @(negedge clock);

        // 6: top word of the ROM
        @(posedge clock); #1 req_valid = 2'b01; req_addr[12:0] = 13'h1FFC;
        wait_grant(g, gap);
        chk("t6_grant", 32'(req_ready), 32'b01);
        push(32'hCAFE07FF, 3'd0, 1'b0);
        @(posedge clock); #1 req_valid = 2'b00;
        @(negedge clock);
        chk("t6_me", 32'(rom_me), 1);
        chk("t6_addr", 32'(rom_address), 32'h7FF);
        repeat (3) @(negedge clock);

        // 5: reset during CAPT (pointer is 1 after the grant to requester 0)
        @(posedge clock); #1 req_valid = 2'b01; req_addr[12:0] = 13'h00C;
        wait_grant(g, gap);
        chk("t5_grant", 32'(req_ready), 32'b01);
        push(32'h5A5A0003, 3'd0, 1'b0);
        @(posedge clock); #1 req_valid = 2'b00;
        @(posedge clock); #1;
        chk("t5_in_capt", 32'(rom_oe), 1);
        #1 reset = 1'b1;
        #1 chk("t5_reset_outs", outs_or(), 0);
        exp_q.delete();
        @(posedge clock); #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("t5_no_stale", 32'(resp_valid), 0);
        end
        @(posedge clock); #1 req_valid = 2'b11; req_addr = {13'h004, 13'h000};
        wait_grant(g, gap);
        chk("t5_ptr_reset", 32'(req_ready), 32'b01);
        push(32'h5A5A0000, 3'd0, 1'b0);
        @(posedge clock); #1 req_valid = 2'b00;
        repeat (4) @(negedge clock);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
